// File: rtl/psm_wdata_packer.sv
// Packs elements from a multi-element FIFO word into masked SRAM column slots.
// Masks and pops travel a DLAT-deep pipeline so that selection lines up with the FIFO read data.
module psm_wdata_packer #(
  parameter int unsigned Y       = 3,
  parameter int unsigned OC_W    = 48,
  parameter int unsigned SRAMC_N = 2,
  parameter int unsigned DLAT    = 2,
  localparam int unsigned BUFF_W  = Y * OC_W,
  localparam int unsigned SRAMC_W = SRAMC_N * OC_W,
  localparam int unsigned CNT_W   = $clog2(Y + SRAMC_N + 1),
  localparam int unsigned EC_W    = $clog2(Y + 1)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [BUFF_W-1:0]   i_fifo_dout,
  input  logic                i_feeder_en,
  input  logic                i_clearbuff,
  input  logic [0:SRAMC_N-1]  i_mask,
  input  logic                i_fifo_pop,
  input  logic                i_autopop_en,
  input  logic                i_err_clr,
  output logic [0:SRAMC_N-1]  o_sramc_wmask,
  output logic [SRAMC_W-1:0]  o_sramc_wdata,
  output logic                o_fifo_pop,
  output logic [EC_W-1:0]     o_elm_cnt,
  output logic                o_underrun
);

  localparam int unsigned PD = (DLAT > 1) ? DLAT - 1 : 1;

  logic [0:SRAMC_N-1] m_q [1:DLAT];
  logic               p_q [1:PD];
  logic [0:SRAMC_N-1] sel_mask;
  logic               sel_pop;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   step;
  logic [CNT_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   idx  [0:SRAMC_N-1];
  logic [OC_W-1:0]    elem [0:SRAMC_N-1];
  logic               autopop;
  logic               fire_pop;
  logic               underrun_ev;

  generate
    if (DLAT == 1) begin : g_sel_d1
      always_comb begin
        sel_mask = i_mask;
        sel_pop  = i_fifo_pop;
      end
    end else begin : g_sel_dn
      always_comb begin
        sel_mask = m_q[DLAT-1];
        sel_pop  = p_q[DLAT-1];
      end
    end
  endgenerate

  // Each set slot takes the element at cnt plus its rank among set slots.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int unsigned j = 0; j < SRAMC_N; j++) begin
      idx[j] = cnt_q + acc;
      acc    = acc + CNT_W'(sel_mask[j]);
    end
    step = acc;
    for (int unsigned j = 0; j < SRAMC_N; j++) begin
      elem[j] = '0;
      for (int unsigned e = 0; e < Y; e++) begin
        if (idx[j] == CNT_W'(e)) elem[j] = i_fifo_dout[e*OC_W +: OC_W];
      end
    end
  end

  // Counter saturates at Y: every value >= Y behaves identically, so it never wraps.
  always_comb begin
    sum         = cnt_q + step;
    cnt_nxt     = (sum > CNT_W'(Y)) ? CNT_W'(Y) : sum;
    autopop     = i_autopop_en & (sum >= CNT_W'(Y)) & (step != '0);
    fire_pop    = (sel_pop | autopop) & i_feeder_en;
    underrun_ev = i_feeder_en & (sum > CNT_W'(Y)) & ~i_clearbuff;
    o_fifo_pop  = fire_pop & i_rstn;
    o_elm_cnt   = (cnt_q >= CNT_W'(Y)) ? EC_W'(Y) : cnt_q[EC_W-1:0];
    o_sramc_wmask = m_q[DLAT];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned k = 1; k <= DLAT; k++) m_q[k] <= '0;
      for (int unsigned k = 1; k <= PD; k++)   p_q[k] <= 1'b0;
      cnt_q         <= '0;
      o_sramc_wdata <= '0;
      o_underrun    <= 1'b0;
    end else begin
      if (i_feeder_en) begin
        m_q[1] <= i_mask;
        for (int unsigned k = 2; k <= DLAT; k++) m_q[k] <= m_q[k-1];
        p_q[1] <= i_fifo_pop;
        for (int unsigned k = 2; k <= PD; k++) p_q[k] <= p_q[k-1];
        for (int unsigned j = 0; j < SRAMC_N; j++) begin
          if (sel_mask[j]) o_sramc_wdata[j*OC_W +: OC_W] <= elem[j];
        end
      end
      // Clear overrides the shift above even while stalled.
      if (i_clearbuff) begin
        for (int unsigned k = 1; k <= PD; k++) p_q[k] <= 1'b0;
      end
      if (i_clearbuff || fire_pop) cnt_q <= '0;
      else if (i_feeder_en)        cnt_q <= cnt_nxt;
      if (underrun_ev)    o_underrun <= 1'b1;
      else if (i_err_clr) o_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psm_wdata_packer.sv
// Directed bench for psm_wdata_packer: main instance Y=3/SRAMC_N=2/OC_W=8/DLAT=2,
// second instance Y=4/SRAMC_N=4 for the non-contiguous mask case.
module tb_psm_wdata_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [23:0] dout;
  logic        en, clr, pop, ape, eclr;
  logic [0:1]  mask;
  logic [0:1]  wmask;
  logic [15:0] wdata;
  logic        fifo_pop;
  logic [1:0]  elm;
  logic        underrun;

  logic [31:0] dout2;
  logic        clr2;
  logic [0:3]  mask2;
  logic [0:3]  wmask2;
  logic [31:0] wdata2;
  logic        fifo_pop2;
  logic [2:0]  elm2;
  logic        underrun2;
  logic        en2, pop2, ape2, eclr2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  psm_wdata_packer #(.Y(3), .OC_W(8), .SRAMC_N(2), .DLAT(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_fifo_dout(dout), .i_feeder_en(en),
    .i_clearbuff(clr), .i_mask(mask), .i_fifo_pop(pop), .i_autopop_en(ape),
    .i_err_clr(eclr), .o_sramc_wmask(wmask), .o_sramc_wdata(wdata),
    .o_fifo_pop(fifo_pop), .o_elm_cnt(elm), .o_underrun(underrun)
  );

  psm_wdata_packer #(.Y(4), .OC_W(8), .SRAMC_N(4), .DLAT(2)) dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_fifo_dout(dout2), .i_feeder_en(en2),
    .i_clearbuff(clr2), .i_mask(mask2), .i_fifo_pop(pop2), .i_autopop_en(ape2),
    .i_err_clr(eclr2), .o_sramc_wmask(wmask2), .o_sramc_wdata(wdata2),
    .o_fifo_pop(fifo_pop2), .o_elm_cnt(elm2), .o_underrun(underrun2)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b1; en = 1'b1; clr = 1'b0; pop = 1'b0; ape = 1'b0; eclr = 1'b0;
    mask = 2'b00; dout = 24'h332211;
    en2 = 1'b1; clr2 = 1'b0; pop2 = 1'b0; ape2 = 1'b0; eclr2 = 1'b0;
    mask2 = 4'b0000; dout2 = 32'h44332211;
    #2 rstn = 1'b0;
    mask = 2'b11; pop = 1'b1;
    #1;
    check_val("rst_wdata", 64'(wdata), 64'h0);
    check_val("rst_wmask", 64'(wmask), 64'h0);
    check_val("rst_elm", 64'(elm), 64'h0);
    check_val("rst_underrun", 64'(underrun), 64'h0);
    check_val("rst_pop", 64'(fifo_pop), 64'h0);
    tick; tick;
    check_val("rst_hold_wmask", 64'(wmask), 64'h0);
    mask = 2'b00; pop = 1'b0;
    rstn = 1'b1;
    tick;

    // Non-contiguous mask on the 4-slot instance
    mask2 = 4'b1111; tick;
    mask2 = 4'b0000; tick;
    clr2 = 1'b1; mask2 = 4'b1010; #1;
    check_val("nc_full_cnt", 64'(elm2), 64'h4);
    tick;
    clr2 = 1'b0; mask2 = 4'b0000; tick;
    #1;
    check_val("nc_wdata", 64'(wdata2), 64'h44222211);
    check_val("nc_wmask", 64'(wmask2), 64'hA);
    check_val("nc_elm", 64'(elm2), 64'h2);

    // Two requests with external pop on the second
    mask = 2'b11; pop = 1'b0; tick;
    mask = 2'b10; pop = 1'b1; #1;
    check_val("ext_pop_early", 64'(fifo_pop), 64'h0);
    tick;
    mask = 2'b00; pop = 1'b0; #1;
    check_val("ext_wdata1", 64'(wdata), 64'h2211);
    check_val("ext_wmask1", 64'(wmask), 64'h3);
    check_val("ext_elm1", 64'(elm), 64'h2);
    check_val("ext_pop", 64'(fifo_pop), 64'h1);
    tick;
    #1;
    check_val("ext_wdata2", 64'(wdata), 64'h2233);
    check_val("ext_wmask2", 64'(wmask), 64'h2);
    check_val("ext_elm2", 64'(elm), 64'h0);
    check_val("ext_pop_done", 64'(fifo_pop), 64'h0);
    tick;

    // Autopop when the word is exhausted
    ape = 1'b1;
    mask = 2'b11; tick;
    mask = 2'b01; #1;
    check_val("ap_pop_early", 64'(fifo_pop), 64'h0);
    tick;
    mask = 2'b00; #1;
    check_val("ap_pop", 64'(fifo_pop), 64'h1);
    check_val("ap_elm_pre", 64'(elm), 64'h2);
    tick;
    #1;
    check_val("ap_elm", 64'(elm), 64'h0);
    check_val("ap_wdata", 64'(wdata), 64'h3311);
    check_val("ap_pop_after", 64'(fifo_pop), 64'h0);
    ape = 1'b0;

    // Underrun, and set winning over a simultaneous clear
    mask = 2'b11; tick;
    mask = 2'b11; tick;
    mask = 2'b11; tick;
    mask = 2'b00; eclr = 1'b1; #1;
    check_val("ur_flag", 64'(underrun), 64'h1);
    check_val("ur_wdata", 64'(wdata), 64'h0033);
    check_val("ur_elm", 64'(elm), 64'h3);
    tick;
    #1;
    check_val("ur_set_wins", 64'(underrun), 64'h1);
    check_val("ur_wdata_zero", 64'(wdata), 64'h0000);
    tick;
    eclr = 1'b0; #1;
    check_val("ur_cleared", 64'(underrun), 64'h0);
    clr = 1'b1; tick;
    clr = 1'b0; #1;
    check_val("ur_clrbuff_elm", 64'(elm), 64'h0);

    // Stall for three cycles mid-stream
    mask = 2'b10; tick;
    mask = 2'b01; tick;
    en = 1'b0; mask = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall_wdata", 64'(wdata), 64'h0011);
      check_val("stall_wmask", 64'(wmask), 64'h2);
      check_val("stall_elm", 64'(elm), 64'h1);
      check_val("stall_pop", 64'(fifo_pop), 64'h0);
      tick;
    end
    en = 1'b1; mask = 2'b00; #1;
    check_val("stall_end_wdata", 64'(wdata), 64'h0011);
    check_val("stall_end_elm", 64'(elm), 64'h1);
    tick;
    #1;
    check_val("resume_wdata", 64'(wdata), 64'h2211);
    check_val("resume_wmask", 64'(wmask), 64'h1);
    check_val("resume_elm", 64'(elm), 64'h2);

    // Clearbuff while stalled drops the pending pop
    pop = 1'b1; tick;
    pop = 1'b0; en = 1'b0; clr = 1'b1; #1;
    check_val("clr_stalled_pop", 64'(fifo_pop), 64'h0);
    check_val("clr_pre_elm", 64'(elm), 64'h2);
    tick;
    en = 1'b1; clr = 1'b0; #1;
    check_val("clr_elm", 64'(elm), 64'h0);
    check_val("clr_pop_dropped", 64'(fifo_pop), 64'h0);

    // Asynchronous reset mid-stream
    mask = 2'b11; tick;
    mask = 2'b11; tick;
    #1;
    check_val("pre_rst_wdata", 64'(wdata), 64'h2211);
    rstn = 1'b0; #1;
    check_val("mid_rst_wdata", 64'(wdata), 64'h0);
    check_val("mid_rst_wmask", 64'(wmask), 64'h0);
    check_val("mid_rst_elm", 64'(elm), 64'h0);
    check_val("mid_rst_underrun", 64'(underrun), 64'h0);
    check_val("mid_rst_pop", 64'(fifo_pop), 64'h0);
    tick;
    mask = 2'b00; rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_val("post_rst_wmask", 64'(wmask), 64'h0);
      check_val("post_rst_wdata", 64'(wdata), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psm_wdata_packer.md
PSM_WDATA_PACKER -- requirements
Module: psm_wdata_packer

Interface
REQ-001 Parameter Y, default 3: number of elements per FIFO word.
REQ-002 Parameter OC_W, default 48: element width in bits.
REQ-003 Parameter SRAMC_N, default 2: number of element slots per SRAM column word.
REQ-004 Parameter DLAT, default 2 (legal range 1..4): latency of i_fifo_dout, in enabled cycles, relative to i_mask and i_fifo_pop.
REQ-005 Derived: BUFF_W=Y*OC_W; SRAMC_W=SRAMC_N*OC_W; CNT_W=$clog2(Y+SRAMC_N+1).
REQ-006 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port i_rstn, input, 1: asynchronous active-low reset.
REQ-008 Port i_fifo_dout, input, BUFF_W: FIFO word; element e occupies bits [e*OC_W +: OC_W].
REQ-009 Port i_feeder_en, input, 1: global pipeline enable; low stalls all registers except those named in REQ-019.
REQ-010 Port i_clearbuff, input, 1: synchronous clear of the element counter and pop pipeline.
REQ-011 Port i_mask, input, [0:SRAMC_N-1]: slots to be written for this request; any bit pattern is legal, including non-contiguous patterns.
REQ-012 Port i_fifo_pop, input, 1: external request to advance to the next FIFO word.
REQ-013 Port i_autopop_en, input, 1: enables automatic pop when the current word is exhausted.
REQ-014 Port i_err_clr, input, 1: clears o_underrun.
REQ-015 Port o_sramc_wmask, output, [0:SRAMC_N-1]: write mask aligned with o_sramc_wdata.
REQ-016 Port o_sramc_wdata, output, SRAMC_W: packed output; slot j occupies bits [j*OC_W +: OC_W].
REQ-017 Port o_fifo_pop, output, 1: effective pop towards the FIFO.
REQ-018 Port o_elm_cnt, output, $clog2(Y+1): registered index of the next unconsumed element.
REQ-019 Port o_underrun, output, 1: sticky flag, set when a request overruns the current FIFO word.

Function
REQ-020 Define m_0=i_mask and m_k=m_{k-1} delayed one enabled cycle; p_k is defined likewise from i_fifo_pop.
REQ-021 The selection stage SHALL use m_{DLAT-1} together with i_fifo_dout; o_sramc_wmask SHALL equal m_DLAT, which is registered.
REQ-022 Rank r_j = popcount(m_{DLAT-1}[0..j-1]); step = popcount(m_{DLAT-1}).
REQ-023 For each j with m_{DLAT-1}[j]=1 and i_feeder_en=1, slot j SHALL load element cnt+r_j if cnt+r_j<Y, and 0 otherwise.
REQ-024 Slots whose mask bit is 0, and all slots while i_feeder_en=0, SHALL hold their value.
REQ-025 autopop = i_autopop_en & (cnt+step >= Y) & (step != 0); pop_eff = p_{DLAT-1} | autopop.
REQ-026 o_fifo_pop SHALL equal pop_eff & i_feeder_en; it is combinational from registered state and i_autopop_en.
REQ-027 Counter next value: 0 if i_clearbuff or (pop_eff & i_feeder_en); else cnt+step if i_feeder_en; else hold.
REQ-028 i_clearbuff SHALL act regardless of i_feeder_en and SHALL zero p_1..p_{DLAT-1}.
REQ-029 Counter arithmetic SHALL be CNT_W wide and never wrap; o_elm_cnt = min(cnt, Y).
REQ-030 Underrun event: i_feeder_en & (cnt+step > Y) with no i_clearbuff in the same cycle.
REQ-031 An underrun event SHALL set o_underrun on the next edge; i_err_clr clears it; set wins over a simultaneous clear.
REQ-032 If i_clearbuff and pop_eff coincide, the counter SHALL go to 0 and o_fifo_pop SHALL still assert.
REQ-033 A zero mask SHALL leave the counter and slots unchanged and SHALL NOT trigger autopop.

Reset
REQ-034 While i_rstn=0, the following SHALL be 0 asynchronously: all m_k and p_k registers, the counter, the slot registers, o_underrun, o_sramc_wmask and o_sramc_wdata.
REQ-035 While i_rstn=0, o_fifo_pop and o_elm_cnt SHALL read 0.
REQ-036 Reset asserted mid-operation SHALL discard in-flight masks and pops; no write mask SHALL appear after deassertion until a new i_mask propagates through DLAT cycles.

Verification (Y=3, SRAMC_N=2, OC_W=8, DLAT=2, i_feeder_en=1 unless stated)
REQ-037 Word 0x332211; masks 11 then 10 with an external pop on the 2nd request -> wdata 0x2211 with wmask 11, then slot0=0x33 with wmask 10; o_fifo_pop on the 2nd selection cycle; cnt returns to 0.
REQ-038 Non-contiguous mask: SRAMC_N=4, Y=4, word 0x44332211, mask 1010 -> slot0=0x11, slot2=0x22, slots 1 and 3 held, o_elm_cnt=2.
REQ-039 i_autopop_en=1; masks 11 then 01 on word 0x332211 -> 2nd request writes slot1=0x33, o_fifo_pop asserts, and the counter is 0 on the next cycle.
REQ-040 Mask 11 with cnt=2 -> slot0=0x33, slot1=0, o_underrun=1; assert i_err_clr together with a new underrun -> o_underrun stays 1.
REQ-041 Stall: drop i_feeder_en for 3 cycles mid-stream -> outputs, counter and wmask frozen; after release, the data sequence matches the unstalled reference.
REQ-042 Assert i_clearbuff with i_feeder_en=0 while cnt=2 -> cnt=0 next cycle and pending p_1 dropped; also assert i_rstn low mid-stream -> all outputs 0 immediately.
